// File: rtl/alu_cmd_initiator_if.sv
// Command, ALU and response signal bundle for alu_cmd_initiator.
// master = the initiator block, slave = the command source, the ALU and the response sink.
interface alu_cmd_initiator_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned OP_W   = 3
);
    localparam int unsigned TAG_W = 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [OP_W-1:0]   cmd_op;
    logic              cmd_chain;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [OP_W-1:0]   rsp_op;
    logic [TAG_W-1:0]  rsp_tag;
    logic              err_mismatch;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_result, rsp_op, rsp_tag, err_mismatch
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_result, rsp_op, rsp_tag, err_mismatch
    );
endinterface

// File: rtl/alu_cmd_initiator.sv
// Issues one command at a time to an external combinational ALU and returns the captured result.
// Optional result checker enabled by macro ALU_CMD_INITIATOR_CHECK_EN.
module alu_cmd_initiator #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned OP_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_initiator_if.master  io_bus
);
    localparam int unsigned TAG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_capture;
    logic              w_rsp_hs;

    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_rsp_result;
    logic [OP_W-1:0]   r_rsp_op;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic [DATA_W-1:0] r_last;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and transaction strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.cmd_valid && r_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (r_rsp_valid && io_bus.rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake flags track the upcoming state so they stay registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
        end
    end

    // Operand issue, result capture and sequence numbering
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_result <= '0;
            r_rsp_op     <= '0;
            r_rsp_tag    <= '0;
            r_last       <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= io_bus.cmd_chain ? r_last : io_bus.cmd_a;
                r_alu_b  <= io_bus.cmd_b;
                r_alu_op <= io_bus.cmd_op;
            end
            if (w_capture) begin
                r_rsp_result <= io_bus.alu_result;
                r_rsp_op     <= r_alu_op;
                r_last       <= io_bus.alu_result;
            end
            if (w_rsp_hs) begin
                r_rsp_tag <= r_rsp_tag + TAG_W'(1);
            end
        end
    end

`ifdef ALU_CMD_INITIATOR_CHECK_EN
    logic [DATA_W-1:0] w_expected;
    logic              r_err;

    // Reference result for the operands currently presented to the ALU
    always_comb begin
        w_expected = '0;
        case (r_alu_op)
            OP_W'(0): w_expected = r_alu_a + r_alu_b;
            OP_W'(1): w_expected = r_alu_a - r_alu_b;
            OP_W'(2): w_expected = r_alu_a & r_alu_b;
            OP_W'(3): w_expected = r_alu_a | r_alu_b;
            OP_W'(4): w_expected = r_alu_a ^ r_alu_b;
            default:  w_expected = '0;
        endcase
    end

    // Sticky until reset
    always_ff @(posedge clk) begin
        if (!rst_n)                                           r_err <= 1'b0;
        else if (w_capture && (io_bus.alu_result != w_expected)) r_err <= 1'b1;
    end

    assign io_bus.err_mismatch = r_err;
`else
    assign io_bus.err_mismatch = 1'b0;
`endif

    assign io_bus.cmd_ready  = r_cmd_ready;
    assign io_bus.rsp_valid  = r_rsp_valid;
    assign io_bus.alu_a      = r_alu_a;
    assign io_bus.alu_b      = r_alu_b;
    assign io_bus.alu_op     = r_alu_op;
    assign io_bus.rsp_result = r_rsp_result;
    assign io_bus.rsp_op     = r_rsp_op;
    assign io_bus.rsp_tag    = r_rsp_tag;
endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Self-checking bench for alu_cmd_initiator: directed scenarios plus random commands
// compared against a transaction-level model (last result, tag counter, sticky error).
module tb_alu_cmd_initiator;
    logic clk;
    logic rst_n;

    alu_cmd_initiator_if #(.DATA_W(4), .OP_W(3)) u_bus ();

    alu_cmd_initiator #(.DATA_W(4), .OP_W(3)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (u_bus)
    );

    int       n_total;
    int       n_bad;
    logic [3:0] m_last;
    int       m_tag;
    logic     m_err;
    bit       force_en;
    logic [3:0] force_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return 4'((a + b) % 16);
            3'd1:    return 4'((16 + a - b) % 16);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 4'h0;
        endcase
    endfunction

    // External ALU, with an override to emulate a faulty unit
    always_comb u_bus.alu_result = force_en ? force_val : ref_alu(u_bus.alu_a, u_bus.alu_b, u_bus.alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        u_bus.cmd_valid = 1'b0;
        u_bus.cmd_chain = 1'b0;
        u_bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(u_bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(u_bus.rsp_valid), 32'd0);
        check("rst_rsp_tag",   32'(u_bus.rsp_tag), 32'd0);
        check("rst_alu_a",     32'(u_bus.alu_a), 32'd0);
        check("rst_alu_b",     32'(u_bus.alu_b), 32'd0);
        check("rst_alu_op",    32'(u_bus.alu_op), 32'd0);
        check("rst_rsp_res",   32'(u_bus.rsp_result), 32'd0);
        check("rst_err",       32'(u_bus.err_mismatch), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_last = 4'h0;
        m_tag  = 0;
        m_err  = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                           input bit chain, input int hold);
        logic [3:0] ea;
        logic [3:0] er;
        int waited;
        @(negedge clk);
        waited = 0;
        while (!u_bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_ready_wait", 32'(u_bus.cmd_ready), 32'd1);
        u_bus.cmd_a     = a;
        u_bus.cmd_b     = b;
        u_bus.cmd_op    = op;
        u_bus.cmd_chain = chain;
        u_bus.cmd_valid = 1'b1;
        ea = chain ? m_last : a;
        er = force_en ? force_val : ref_alu(ea, b, op);
        @(posedge clk);  // accept edge N
        #1;
        u_bus.cmd_valid = 1'b0;
        u_bus.cmd_chain = 1'b0;
        check("drv_alu_a",     32'(u_bus.alu_a), 32'(ea));
        check("drv_alu_b",     32'(u_bus.alu_b), 32'(b));
        check("drv_alu_op",    32'(u_bus.alu_op), 32'(op));
        check("drv_cmd_ready", 32'(u_bus.cmd_ready), 32'd0);
        check("drv_rsp_valid", 32'(u_bus.rsp_valid), 32'd0);
        @(posedge clk);  // capture edge; rsp_valid seen high by the sink at edge N+2
        #1;
        m_last = er;
`ifdef ALU_CMD_INITIATOR_CHECK_EN
        if (er != ref_alu(ea, b, op)) m_err = 1'b1;
`endif
        check("rsp_valid",   32'(u_bus.rsp_valid), 32'd1);
        check("rsp_result",  32'(u_bus.rsp_result), 32'(er));
        check("rsp_op",      32'(u_bus.rsp_op), 32'(op));
        check("rsp_tag",     32'(u_bus.rsp_tag), 32'(m_tag));
        check("rsp_ready_lo", 32'(u_bus.cmd_ready), 32'd0);
        check("err",         32'(u_bus.err_mismatch), 32'(m_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid",  32'(u_bus.rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(u_bus.rsp_result), 32'(er));
            check("bp_rsp_tag",    32'(u_bus.rsp_tag), 32'(m_tag));
            check("bp_cmd_ready",  32'(u_bus.cmd_ready), 32'd0);
        end
        @(negedge clk);
        u_bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        u_bus.rsp_ready = 1'b0;
        m_tag = (m_tag + 1) % 256;
        check("hs_rsp_valid", 32'(u_bus.rsp_valid), 32'd0);
        check("hs_cmd_ready", 32'(u_bus.cmd_ready), 32'd1);
        check("hs_alu_hold",  32'(u_bus.alu_a), 32'(ea));
        check("hs_err",       32'(u_bus.err_mismatch), 32'(m_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0;
        n_bad = 0;
        force_en = 1'b0;
        force_val = 4'h0;
        rst_n = 1'b0;
        u_bus.cmd_valid = 1'b0;
        u_bus.cmd_a = 4'h0;
        u_bus.cmd_b = 4'h0;
        u_bus.cmd_op = 3'd0;
        u_bus.cmd_chain = 1'b0;
        u_bus.rsp_ready = 1'b0;

        do_reset();
        run_cmd(4'h9, 4'h8, 3'd0, 1'b0, 0);      // wrap add -> 1, tag 0

        do_reset();
        run_cmd(4'h3, 4'h2, 3'd0, 1'b0, 0);      // 5, tag 0
        run_cmd(4'h0, 4'h7, 3'd1, 1'b1, 5);      // chain 5-7 -> E, tag 1, backpressure

        // Faulty ALU on an unchecked opcode, then a clean command to show stickiness
        force_en = 1'b1;
        force_val = 4'h1;
        run_cmd(4'hF, 4'hF, 3'd6, 1'b0, 0);
        force_en = 1'b0;
        run_cmd(4'h1, 4'h1, 3'd0, 1'b0, 1);

        // Reset while in DRIVE drops the command and clears the last result
        run_cmd(4'h7, 4'h1, 3'd0, 1'b0, 0);
        @(negedge clk);
        u_bus.cmd_a = 4'h6;
        u_bus.cmd_b = 4'h6;
        u_bus.cmd_op = 3'd0;
        u_bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        u_bus.cmd_valid = 1'b0;
        check("mid_alu_a", 32'(u_bus.alu_a), 32'h6);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rsp_valid", 32'(u_bus.rsp_valid), 32'd0);
        check("mid_cmd_ready", 32'(u_bus.cmd_ready), 32'd1);
        check("mid_rsp_tag",   32'(u_bus.rsp_tag), 32'd0);
        check("mid_err",       32'(u_bus.err_mismatch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 4'h0;
        m_tag = 0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        check("mid_no_pulse", 32'(u_bus.rsp_valid), 32'd0);
        run_cmd(4'hA, 4'h3, 3'd0, 1'b1, 0);      // chain after reset uses 0 -> 3

        // Random traffic, long enough to wrap the tag
        for (int i = 0; i < 270; i++) begin
            run_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
